// File: rtl/cpu_switchover_sequencer.sv
// Make-before-break handover of the active CPU between redundant cores A and B.
// Powers up the standby core, waits for a stable heartbeat, moves the switch, then powers off the old core.
module cpu_switchover_sequencer #(
    parameter int CNT_W          = 32,
    parameter int PWR_SETTLE_CYC = 1000,
    parameter int HB_STABLE_CYC  = 16,
    parameter int HB_TIMEOUT_CYC = 50000,
    parameter int OFF_DELAY_CYC  = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_target,
    output logic req_ready,
    input  logic heartbeat_A,
    input  logic heartbeat_B,
    output logic power_on_A,
    output logic power_on_B,
    output logic switch,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        WAIT_HB,
        SWITCH,
        OFF_WAIT,
        ABORT
    } state_t;

    localparam logic [63:0]      CNT_LIMIT    = 64'd1 << CNT_W;
    localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(PWR_SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(HB_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] OFF_LAST     = CNT_W'(OFF_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_N     = CNT_W'(HB_STABLE_CYC);

    // Reject parameter sets that cannot be represented by the phase counters.
    generate
        if (PWR_SETTLE_CYC < 1 || HB_STABLE_CYC < 1 || OFF_DELAY_CYC < 1 ||
            HB_TIMEOUT_CYC <= HB_STABLE_CYC ||
            64'(PWR_SETTLE_CYC) >= CNT_LIMIT || 64'(HB_STABLE_CYC) >= CNT_LIMIT ||
            64'(HB_TIMEOUT_CYC) >= CNT_LIMIT || 64'(OFF_DELAY_CYC) >= CNT_LIMIT) begin : g_param_check
            $error("cpu_switchover_sequencer: illegal parameter combination");
        end
    endgenerate

    state_t           state;
    logic             tgt;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] stab;
    logic [CNT_W-1:0] stab_next;
    logic             hb_tgt;
    logic             stab_hit;
    logic             timeout_hit;
    logic             accept;

    always_comb begin
        hb_tgt = tgt ? heartbeat_B : heartbeat_A;
        stab_next = '0;
        if (hb_tgt) begin
            stab_next = (stab == '1) ? stab : stab + ONE;
        end
        stab_hit    = (stab_next == STABLE_N);
        timeout_hit = (counter == TIMEOUT_LAST);
        accept      = req_valid & req_ready;
    end

    // Stability wins over timeout when both land on the same WAIT_HB cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tgt        <= 1'b0;
            counter    <= '0;
            stab       <= '0;
            power_on_A <= 1'b1;
            power_on_B <= 1'b0;
            switch     <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tgt <= req_target;
                        if (req_target == switch) begin
                            done <= 1'b1;
                        end else begin
                            if (req_target) power_on_B <= 1'b1;
                            else            power_on_A <= 1'b1;
                            counter   <= '0;
                            stab      <= '0;
                            state     <= SETTLE;
                            busy      <= 1'b1;
                            req_ready <= 1'b0;
                        end
                    end
                end
                SETTLE: begin
                    if (counter == SETTLE_LAST) begin
                        counter <= '0;
                        stab    <= '0;
                        state   <= WAIT_HB;
                    end else begin
                        counter <= counter + ONE;
                    end
                end
                WAIT_HB: begin
                    stab    <= stab_next;
                    counter <= counter + ONE;
                    if (stab_hit) begin
                        counter <= '0;
                        state   <= SWITCH;
                    end else if (timeout_hit) begin
                        counter <= '0;
                        state   <= ABORT;
                    end
                end
                SWITCH: begin
                    switch  <= tgt;
                    counter <= '0;
                    state   <= OFF_WAIT;
                end
                OFF_WAIT: begin
                    if (counter == OFF_LAST) begin
                        if (tgt) power_on_A <= 1'b0;
                        else     power_on_B <= 1'b0;
                        done      <= 1'b1;
                        counter   <= '0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else begin
                        counter <= counter + ONE;
                    end
                end
                ABORT: begin
                    // Only the core we tried to bring up is dropped; the active one is untouched.
                    if (tgt) power_on_B <= 1'b0;
                    else     power_on_A <= 1'b0;
                    err       <= 1'b1;
                    counter   <= '0;
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    counter   <= '0;
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/cpu_switchover_sequencer.md
Name: cpu_switchover_sequencer

Overview:
- Sequences an ordered, make-before-break handover of the active CPU between the dual-redundant cores A and B.
- Brings up the standby CPU, waits for its power to settle, then waits for a stable heartbeat.
- Only after the heartbeat is stable does it move the signal switch, and only after a hold delay does it power down the old CPU.
- Sits beside the signal/power control logic. It is driven by the UART command decoder or the fail-detect logic through a valid/ready request port, and it owns the power-enable and switch outputs while a sequence runs.

Parameters:
- CNT_W, 32, width of the shared phase counter.
- PWR_SETTLE_CYC, 1000, cycles to wait after power-on before heartbeat is sampled (>=1).
- HB_STABLE_CYC, 16, consecutive heartbeat-high cycles required on the target CPU (>=1).
- HB_TIMEOUT_CYC, 50000, maximum cycles spent waiting for a stable heartbeat (>HB_STABLE_CYC).
- OFF_DELAY_CYC, 500, cycles between the switch moving and the old CPU being powered off (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  switchover request
- req_target  in  1  requested active CPU: 0=A, 1=B
- req_ready  out  1  high only in IDLE
- heartbeat_A  in  1  CPU A alive (level, high=alive)
- heartbeat_B  in  1  CPU B alive
- power_on_A  out  1  CPU A power enable
- power_on_B  out  1  CPU B power enable
- switch  out  1  signal routing: 0=A, 1=B
- busy  out  1  sequence in progress (state != IDLE)
- done  out  1  one-cycle pulse: sequence completed or no-op
- err  out  1  one-cycle pulse: heartbeat timeout, sequence aborted

Behaviour:
- All outputs are registered.
- Reset state: power_on_A=1, power_on_B=0, switch=0, req_ready=1, busy=0, done=0, err=0, state=IDLE, counter=0.
- Reset mid-sequence returns to exactly these values on the next edge; no partial power state is retained.
- Handshake: a request is accepted on an edge where req_valid & req_ready. req_target is latched into tgt on accept. req_ready=0 from the cycle after accept until the state returns to IDLE. Requests while busy are ignored (not queued).
- IDLE:
  - If accept and tgt==switch: no-op. done=1 in the next cycle, outputs unchanged, state stays IDLE.
  - If accept and tgt!=switch: next cycle power_on_tgt=1, counter=0, state=SETTLE.
- SETTLE:
  - Counter increments each cycle.
  - When counter==PWR_SETTLE_CYC-1: counter cleared, state=WAIT_HB. SETTLE therefore lasts exactly PWR_SETTLE_CYC cycles.
- WAIT_HB:
  - The timeout counter increments every cycle.
  - A separate stability counter increments while heartbeat_tgt=1 and clears to 0 on any low cycle. It saturates and never wraps.
  - When the stability count reaches HB_STABLE_CYC: state=SWITCH.
  - Else if the timeout counter reaches HB_TIMEOUT_CYC-1: state=ABORT.
  - If both occur on the same cycle, stability wins and the state goes to SWITCH.
- SWITCH (1 cycle): switch<=tgt, counter cleared, state=OFF_WAIT.
- OFF_WAIT:
  - Counts OFF_DELAY_CYC cycles.
  - On the last cycle: power_on of the old CPU (!tgt) <= 0, done=1 on the next cycle, state=IDLE.
- ABORT (1 cycle):
  - power_on_tgt<=0 and err=1 on the next cycle.
  - switch and the old CPU's power are unchanged. state=IDLE.
- Invariants:
  - The active CPU (index given by switch) is always powered.
  - Both CPUs are powered together only between SETTLE entry and OFF_WAIT exit.
  - switch never changes outside SWITCH.
  - done and err are never high together.
- Counters compare with ==, are sized CNT_W, and clear on every state entry. Parameters must fit in CNT_W (static assertion in simulation).

Test Plan:
Use PWR_SETTLE_CYC=4, HB_STABLE_CYC=3, HB_TIMEOUT_CYC=20, OFF_DELAY_CYC=5.
- Reset -> power_on_A=1, power_on_B=0, switch=0, req_ready=1, busy=0.
- req_target=1 at cycle 0, heartbeat_B held high -> power_on_B=1 at cycle 1; switch=1 after 4 settle + 3 stable + 1 cycles; power_on_A=0 and done pulse 5 cycles later; power_on_A/B never both 0.
- heartbeat_B held low after request -> err pulses once after 20 WAIT_HB cycles; power_on_B returns to 0; switch=0; power_on_A=1 throughout.
- heartbeat_B toggling high 2 cycles / low 1 cycle -> never reaches 3 stable, times out with err; then heartbeat_B high for a retry request -> completes with done.
- Request req_target=0 while switch=0 -> done pulse the next cycle; no output change; a second request pulsed during a sequence -> ignored, exactly one done.
- rst asserted during OFF_WAIT -> next cycle all outputs equal reset values; a new request then completes normally.
